// File: rtl/decode_stage_rv.sv
// decode_stage_rv: registered RV32I/RV64I decode stage sitting between IF and EX.
//
// Decodes each instruction into a 22-bit control word before registering it, so every
// out_* signal comes straight from a flop. A one-entry skid buffer lets in_ready be a
// registered signal while still sustaining one instruction per cycle.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   flush            drop every held instruction (branch redirect)
//   in_valid/ready   upstream handshake; in_inst, in_pc carry the instruction
//   out_valid/ready  downstream handshake; out_sign, out_inst, out_pc, out_illegal
//   cnt_retired      count of downstream handshakes (wraps)
//   cnt_illegal      count of downstream handshakes carrying an illegal instruction (wraps)
//
// Control word: [21]we_reg [20]we_mem [19]npc_sel [18:16]immgen_op [15:12]alu_op
//   [11:9]bralu_op [8:7]alu_asel [6:5]alu_bsel [4:3]wb_sel [2:0]memdata_width
module decode_stage_rv #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [21:0]      out_sign,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] cnt_retired,
  output logic [CNT_W-1:0] cnt_illegal
);

  localparam bit Rv64 = (XLEN == 64);

  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcOp32    = 7'b0111011;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcJal     = 7'b1101111;

  localparam logic [2:0] ImmR = 3'b000, ImmI = 3'b001, ImmS = 3'b010;
  localparam logic [2:0] ImmB = 3'b011, ImmU = 3'b100, ImmJ = 3'b101;

  localparam logic [3:0] AluAdd  = 4'b0000, AluSub  = 4'b0001, AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011, AluXor  = 4'b0100, AluSlt  = 4'b0101;
  localparam logic [3:0] AluSltu = 4'b0110, AluSll  = 4'b0111, AluSrl  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001, AluAddw = 4'b1010, AluSubw = 4'b1011;
  localparam logic [3:0] AluSllw = 4'b1100, AluSrlw = 4'b1101, AluSraw = 4'b1110;

  localparam logic [1:0] ASelZero = 2'b00, ASelRs1 = 2'b01, ASelPc = 2'b10;
  localparam logic [1:0] BSelRs2 = 2'b01, BSelImm = 2'b10;
  localparam logic [1:0] WbNone = 2'b00, WbAlu = 2'b01, WbMem = 2'b10, WbPc4 = 2'b11;

  localparam logic [2:0] MwNone = 3'b000, MwD = 3'b001, MwW = 3'b010, MwH = 3'b011;
  localparam logic [2:0] MwB = 3'b100, MwWu = 3'b101, MwHu = 3'b110, MwBu = 3'b111;

  localparam logic [6:0] F7Zero = 7'b0000000, F7Alt = 7'b0100000;

  typedef struct packed {
    logic [21:0]     sign;
    logic            illegal;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  logic       we_reg, we_mem, npc_sel, illegal;
  logic [2:0] imm_op, br_op, mem_w;
  logic [3:0] alu_op;
  logic [1:0] asel, bsel, wb_sel;
  entry_t     dec;

  always_comb begin
    we_reg  = 1'b0;
    we_mem  = 1'b0;
    npc_sel = 1'b0;
    imm_op  = ImmR;
    alu_op  = AluAdd;
    br_op   = 3'b000;
    asel    = ASelZero;
    bsel    = 2'b00;
    wb_sel  = WbNone;
    mem_w   = MwNone;
    illegal = 1'b0;

    case (opcode)
      OpcOpImm: begin
        we_reg = 1'b1;
        imm_op = ImmI;
        asel   = ASelRs1;
        bsel   = BSelImm;
        wb_sel = WbAlu;
        case (funct3)
          3'b000: alu_op = AluAdd;
          3'b010: alu_op = AluSlt;
          3'b011: alu_op = AluSltu;
          3'b100: alu_op = AluXor;
          3'b110: alu_op = AluOr;
          3'b111: alu_op = AluAnd;
          3'b001: begin
            alu_op = AluSll;
            if (in_inst[31:26] != 6'b000000) illegal = 1'b1;
          end
          default: begin // 3'b101
            if (in_inst[31:26] == 6'b000000) alu_op = AluSrl;
            else if (in_inst[31:26] == 6'b010000) alu_op = AluSra;
            else illegal = 1'b1;
          end
        endcase
        // shamt[5] only exists on RV64
        if (!Rv64 && (funct3 == 3'b001 || funct3 == 3'b101) && in_inst[25]) illegal = 1'b1;
      end

      OpcOpImm32: begin
        we_reg = 1'b1;
        imm_op = ImmI;
        asel   = ASelRs1;
        bsel   = BSelImm;
        wb_sel = WbAlu;
        case (funct3)
          3'b000: alu_op = AluAddw;
          3'b001: begin
            alu_op = AluSllw;
            if (funct7 != F7Zero) illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7Zero) alu_op = AluSrlw;
            else if (funct7 == F7Alt) alu_op = AluSraw;
            else illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
        if (!Rv64) illegal = 1'b1;
      end

      OpcLoad: begin
        we_reg = 1'b1;
        imm_op = ImmI;
        asel   = ASelRs1;
        bsel   = BSelImm;
        wb_sel = WbMem;
        case (funct3)
          3'b000: mem_w = MwB;
          3'b001: mem_w = MwH;
          3'b010: mem_w = MwW;
          3'b011: begin
            mem_w = MwD;
            if (!Rv64) illegal = 1'b1;
          end
          3'b100: mem_w = MwBu;
          3'b101: mem_w = MwHu;
          3'b110: begin
            mem_w = MwWu;
            if (!Rv64) illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end

      OpcOp: begin
        we_reg = 1'b1;
        asel   = ASelRs1;
        bsel   = BSelRs2;
        wb_sel = WbAlu;
        case ({funct7, funct3})
          {F7Zero, 3'b000}: alu_op = AluAdd;
          {F7Alt,  3'b000}: alu_op = AluSub;
          {F7Zero, 3'b001}: alu_op = AluSll;
          {F7Zero, 3'b010}: alu_op = AluSlt;
          {F7Zero, 3'b011}: alu_op = AluSltu;
          {F7Zero, 3'b100}: alu_op = AluXor;
          {F7Zero, 3'b101}: alu_op = AluSrl;
          {F7Alt,  3'b101}: alu_op = AluSra;
          {F7Zero, 3'b110}: alu_op = AluOr;
          {F7Zero, 3'b111}: alu_op = AluAnd;
          default:          illegal = 1'b1;
        endcase
      end

      OpcOp32: begin
        we_reg = 1'b1;
        asel   = ASelRs1;
        bsel   = BSelRs2;
        wb_sel = WbAlu;
        case ({funct7, funct3})
          {F7Zero, 3'b000}: alu_op = AluAddw;
          {F7Alt,  3'b000}: alu_op = AluSubw;
          {F7Zero, 3'b001}: alu_op = AluSllw;
          {F7Zero, 3'b101}: alu_op = AluSrlw;
          {F7Alt,  3'b101}: alu_op = AluSraw;
          default:          illegal = 1'b1;
        endcase
        if (!Rv64) illegal = 1'b1;
      end

      OpcStore: begin
        we_mem = 1'b1;
        imm_op = ImmS;
        asel   = ASelRs1;
        bsel   = BSelImm;
        case (funct3)
          3'b000: mem_w = MwB;
          3'b001: mem_w = MwH;
          3'b010: mem_w = MwW;
          3'b011: begin
            mem_w = MwD;
            if (!Rv64) illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end

      OpcBranch: begin
        imm_op = ImmB;
        asel   = ASelPc;
        bsel   = BSelImm;
        case (funct3)
          3'b000: br_op = 3'b001;
          3'b001: br_op = 3'b010;
          3'b100: br_op = 3'b011;
          3'b101: br_op = 3'b100;
          3'b110: br_op = 3'b101;
          3'b111: br_op = 3'b110;
          default: illegal = 1'b1;
        endcase
      end

      OpcJal: begin
        we_reg  = 1'b1;
        npc_sel = 1'b1;
        imm_op  = ImmJ;
        asel    = ASelPc;
        bsel    = BSelImm;
        wb_sel  = WbPc4;
      end

      OpcJalr: begin
        we_reg  = 1'b1;
        npc_sel = 1'b1;
        imm_op  = ImmI;
        asel    = ASelRs1;
        bsel    = BSelImm;
        wb_sel  = WbPc4;
        if (funct3 != 3'b000) illegal = 1'b1;
      end

      OpcLui, OpcAuipc: begin
        we_reg = 1'b1;
        imm_op = ImmU;
        asel   = (opcode == OpcLui) ? ASelZero : ASelPc;
        bsel   = BSelImm;
        wb_sel = WbAlu;
      end

      default: illegal = 1'b1;
    endcase

    dec.illegal = illegal;
    dec.inst    = in_inst;
    dec.pc      = in_pc;
    dec.sign    = illegal ? 22'd0 : {we_reg, we_mem, npc_sel, imm_op, alu_op, br_op,
                                     asel, bsel, wb_sel, mem_w};
  end

  // ---------------------------------------------------------------------------
  // Main register + skid register, with registered handshake outputs
  // ---------------------------------------------------------------------------
  state_e           state_q;
  entry_t           main_q, skid_q;
  logic             out_valid_q, in_ready_q;
  logic [CNT_W-1:0] cnt_retired_q, cnt_illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StEmpty;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
      main_q        <= '0;
      skid_q        <= '0;
      cnt_retired_q <= '0;
      cnt_illegal_q <= '0;
    end else begin
      // A handshake completing in the flush cycle has already left the stage, so it counts.
      if (out_valid_q && out_ready) begin
        cnt_retired_q <= cnt_retired_q + CNT_W'(1);
        if (main_q.illegal) cnt_illegal_q <= cnt_illegal_q + CNT_W'(1);
      end

      if (flush) begin
        state_q     <= StEmpty;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (in_valid) begin
              main_q      <= dec;
              state_q     <= StFull;
              out_valid_q <= 1'b1;
            end
          end
          StFull: begin
            if (in_valid) begin
              if (out_ready) begin
                main_q <= dec;
              end else begin
                skid_q     <= dec;
                state_q    <= StSkid;
                in_ready_q <= 1'b0;
              end
            end else if (out_ready) begin
              state_q     <= StEmpty;
              out_valid_q <= 1'b0;
            end
          end
          StSkid: begin
            if (out_ready) begin
              main_q     <= skid_q;
              state_q    <= StFull;
              in_ready_q <= 1'b1;
            end
          end
          default: begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_sign    = main_q.sign;
  assign out_inst    = main_q.inst;
  assign out_pc      = main_q.pc;
  assign out_illegal = main_q.illegal;
  assign cnt_retired = cnt_retired_q;
  assign cnt_illegal = cnt_illegal_q;

endmodule

// File: tb/tb_decode_stage_rv.sv
// Bench for decode_stage_rv: an RV64 and an RV32 instance are driven with the same stream
// and compared every cycle against a queue-based flow model and a mask/match decode table.
module tb_decode_stage_rv;

  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic          a_in_ready, a_out_valid, a_out_illegal;
  logic [21:0]   a_out_sign;
  logic [31:0]   a_out_inst;
  logic [63:0]   a_out_pc;
  logic [CW-1:0] a_cnt_ret, a_cnt_ill;

  logic          b_in_ready, b_out_valid, b_out_illegal;
  logic [21:0]   b_out_sign;
  logic [31:0]   b_out_inst;
  logic [31:0]   b_out_pc;
  logic [CW-1:0] b_cnt_ret, b_cnt_ill;

  decode_stage_rv #(.XLEN(64), .CNT_W(CW)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sign(a_out_sign), .out_inst(a_out_inst), .out_pc(a_out_pc),
    .out_illegal(a_out_illegal), .cnt_retired(a_cnt_ret), .cnt_illegal(a_cnt_ill)
  );

  decode_stage_rv #(.XLEN(32), .CNT_W(CW)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sign(b_out_sign), .out_inst(b_out_inst), .out_pc(b_out_pc),
    .out_illegal(b_out_illegal), .cnt_retired(b_cnt_ret), .cnt_illegal(b_cnt_ill)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- decode reference: mask/match table ----------------
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [21:0] sign;
    bit          rv64;
    bit          sh;    // shift-immediate: shamt[5] must be 0 on RV32
  } pat_t;
  pat_t pats[$];

  function automatic logic [21:0] sg(bit we, bit wm, bit npc, logic [2:0] imm,
                                     logic [3:0] alu, logic [2:0] br, logic [1:0] as,
                                     logic [1:0] bs, logic [1:0] wb, logic [2:0] mw);
    return {we, wm, npc, imm, alu, br, as, bs, wb, mw};
  endfunction

  function automatic logic [21:0] f_i(logic [3:0] alu);
    return sg(1, 0, 0, 3'd1, alu, 3'd0, 2'b01, 2'b10, 2'b01, 3'd0);
  endfunction
  function automatic logic [21:0] f_r(logic [3:0] alu);
    return sg(1, 0, 0, 3'd0, alu, 3'd0, 2'b01, 2'b01, 2'b01, 3'd0);
  endfunction
  function automatic logic [21:0] f_ld(logic [2:0] mw);
    return sg(1, 0, 0, 3'd1, 4'd0, 3'd0, 2'b01, 2'b10, 2'b10, mw);
  endfunction
  function automatic logic [21:0] f_st(logic [2:0] mw);
    return sg(0, 1, 0, 3'd2, 4'd0, 3'd0, 2'b01, 2'b10, 2'b00, mw);
  endfunction
  function automatic logic [21:0] f_br(logic [2:0] b);
    return sg(0, 0, 0, 3'd3, 4'd0, b, 2'b10, 2'b10, 2'b00, 3'd0);
  endfunction

  task automatic add(input logic [31:0] mask, input logic [31:0] match,
                     input logic [21:0] sign, input bit rv64, input bit sh);
    pat_t p;
    p.mask = mask; p.match = match; p.sign = sign; p.rv64 = rv64; p.sh = sh;
    pats.push_back(p);
  endtask

  localparam logic [31:0] MR = 32'hFE00707F, MI = 32'h0000707F;
  localparam logic [31:0] MU = 32'h0000007F, MS = 32'hFC00707F;

  task automatic build_table();
    add(MU, 32'h37, sg(1, 0, 0, 3'd4, 4'd0, 3'd0, 2'b00, 2'b10, 2'b01, 3'd0), 0, 0);   // lui
    add(MU, 32'h17, sg(1, 0, 0, 3'd4, 4'd0, 3'd0, 2'b10, 2'b10, 2'b01, 3'd0), 0, 0);   // auipc
    add(MU, 32'h6F, sg(1, 0, 1, 3'd5, 4'd0, 3'd0, 2'b10, 2'b10, 2'b11, 3'd0), 0, 0);   // jal
    add(MI, 32'h67, sg(1, 0, 1, 3'd1, 4'd0, 3'd0, 2'b01, 2'b10, 2'b11, 3'd0), 0, 0);   // jalr
    add(MI, 32'h0063, f_br(3'd1), 0, 0); add(MI, 32'h1063, f_br(3'd2), 0, 0);
    add(MI, 32'h4063, f_br(3'd3), 0, 0); add(MI, 32'h5063, f_br(3'd4), 0, 0);
    add(MI, 32'h6063, f_br(3'd5), 0, 0); add(MI, 32'h7063, f_br(3'd6), 0, 0);
    add(MI, 32'h0003, f_ld(3'd4), 0, 0); add(MI, 32'h1003, f_ld(3'd3), 0, 0);          // lb lh
    add(MI, 32'h2003, f_ld(3'd2), 0, 0); add(MI, 32'h3003, f_ld(3'd1), 1, 0);          // lw ld
    add(MI, 32'h4003, f_ld(3'd7), 0, 0); add(MI, 32'h5003, f_ld(3'd6), 0, 0);          // lbu lhu
    add(MI, 32'h6003, f_ld(3'd5), 1, 0);                                               // lwu
    add(MI, 32'h0023, f_st(3'd4), 0, 0); add(MI, 32'h1023, f_st(3'd3), 0, 0);
    add(MI, 32'h2023, f_st(3'd2), 0, 0); add(MI, 32'h3023, f_st(3'd1), 1, 0);
    add(MI, 32'h0013, f_i(4'd0), 0, 0);  add(MI, 32'h2013, f_i(4'd5), 0, 0);
    add(MI, 32'h3013, f_i(4'd6), 0, 0);  add(MI, 32'h4013, f_i(4'd4), 0, 0);
    add(MI, 32'h6013, f_i(4'd3), 0, 0);  add(MI, 32'h7013, f_i(4'd2), 0, 0);
    add(MS, 32'h1013, f_i(4'd7), 0, 1);  add(MS, 32'h5013, f_i(4'd8), 0, 1);
    add(MS, 32'h40005013, f_i(4'd9), 0, 1);
    add(MI, 32'h001B, f_i(4'd10), 1, 0); add(MR, 32'h101B, f_i(4'd12), 1, 0);
    add(MR, 32'h501B, f_i(4'd13), 1, 0); add(MR, 32'h4000501B, f_i(4'd14), 1, 0);
    add(MR, 32'h0033, f_r(4'd0), 0, 0);  add(MR, 32'h40000033, f_r(4'd1), 0, 0);
    add(MR, 32'h1033, f_r(4'd7), 0, 0);  add(MR, 32'h2033, f_r(4'd5), 0, 0);
    add(MR, 32'h3033, f_r(4'd6), 0, 0);  add(MR, 32'h4033, f_r(4'd4), 0, 0);
    add(MR, 32'h5033, f_r(4'd8), 0, 0);  add(MR, 32'h40005033, f_r(4'd9), 0, 0);
    add(MR, 32'h6033, f_r(4'd3), 0, 0);  add(MR, 32'h7033, f_r(4'd2), 0, 0);
    add(MR, 32'h003B, f_r(4'd10), 1, 0); add(MR, 32'h4000003B, f_r(4'd11), 1, 0);
    add(MR, 32'h103B, f_r(4'd12), 1, 0); add(MR, 32'h503B, f_r(4'd13), 1, 0);
    add(MR, 32'h4000503B, f_r(4'd14), 1, 0);
  endtask

  task automatic ref_decode(input logic [31:0] inst, input bit x64,
                            output logic [21:0] sign, output logic ill);
    sign = '0;
    ill  = 1'b1;
    foreach (pats[k]) begin
      if ((inst & pats[k].mask) == pats[k].match && (x64 || !pats[k].rv64) &&
          !(pats[k].sh && !x64 && inst[25])) begin
        sign = pats[k].sign;
        ill  = 1'b0;
      end
    end
  endtask

  // ---------------- flow model: a queue of at most two held entries ----------------
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [21:0] s64;
    logic        i64;
    logic [21:0] s32;
    logic        i32;
  } item_t;
  item_t q[$];
  logic [CW-1:0] m_ret, m_ill64, m_ill32;

  task automatic model_reset();
    q.delete();
    m_ret = '0; m_ill64 = '0; m_ill32 = '0;
  endtask

  task automatic check_outputs();
    chk("in_ready64", 64'(a_in_ready), 64'(q.size() < 2));
    chk("in_ready32", 64'(b_in_ready), 64'(q.size() < 2));
    chk("out_valid64", 64'(a_out_valid), 64'(q.size() > 0));
    chk("out_valid32", 64'(b_out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_sign64", 64'(a_out_sign), 64'(q[0].s64));
      chk("out_illegal64", 64'(a_out_illegal), 64'(q[0].i64));
      chk("out_inst64", 64'(a_out_inst), 64'(q[0].inst));
      chk("out_pc64", a_out_pc, q[0].pc);
      chk("out_sign32", 64'(b_out_sign), 64'(q[0].s32));
      chk("out_illegal32", 64'(b_out_illegal), 64'(q[0].i32));
      chk("out_inst32", 64'(b_out_inst), 64'(q[0].inst));
      chk("out_pc32", 64'(b_out_pc), 64'(q[0].pc[31:0]));
    end
    chk("cnt_retired64", 64'(a_cnt_ret), 64'(m_ret));
    chk("cnt_retired32", 64'(b_cnt_ret), 64'(m_ret));
    chk("cnt_illegal64", 64'(a_cnt_ill), 64'(m_ill64));
    chk("cnt_illegal32", 64'(b_cnt_ill), 64'(m_ill32));
  endtask

  task automatic model_step();
    item_t it;
    bit    acc;
    if (rst) begin
      model_reset();
      return;
    end
    acc = in_valid && (q.size() < 2);
    if (q.size() > 0 && out_ready) begin
      it = q.pop_front();
      m_ret++;
      if (it.i64) m_ill64++;
      if (it.i32) m_ill32++;
    end
    if (flush) q.delete();
    else if (acc) begin
      it.inst = in_inst;
      it.pc   = in_pc;
      ref_decode(in_inst, 1'b1, it.s64, it.i64);
      ref_decode(in_inst, 1'b0, it.s32, it.i32);
      q.push_back(it);
    end
  endtask

  // Outputs are compared against the model, then the model advances across the edge.
  task automatic tick();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    int unsigned r;
    pat_t        p;
    logic [31:0] v;
    r = $urandom_range(0, 9);
    p = pats[$urandom_range(0, pats.size() - 1)];
    v = p.match | ($urandom & ~p.mask);
    if (r == 7) v = $urandom;
    else if (r == 8) v = v ^ (32'd1 << $urandom_range(0, 31));
    else if (r == 9) v = $urandom | 32'h3;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid64"}, 64'(a_out_valid), 64'd0);
    chk({tag, "_valid32"}, 64'(b_out_valid), 64'd0);
    chk({tag, "_ready64"}, 64'(a_in_ready), 64'd1);
    chk({tag, "_ready32"}, 64'(b_in_ready), 64'd1);
    chk({tag, "_sign64"}, 64'(a_out_sign), 64'd0);
    chk({tag, "_sign32"}, 64'(b_out_sign), 64'd0);
    chk({tag, "_inst64"}, 64'(a_out_inst), 64'd0);
    chk({tag, "_pc64"}, a_out_pc, 64'd0);
    chk({tag, "_pc32"}, 64'(b_out_pc), 64'd0);
    chk({tag, "_ill64"}, 64'(a_out_illegal), 64'd0);
    chk({tag, "_ill32"}, 64'(b_out_illegal), 64'd0);
    chk({tag, "_ret64"}, 64'(a_cnt_ret), 64'd0);
    chk({tag, "_ret32"}, 64'(b_cnt_ret), 64'd0);
    chk({tag, "_cill64"}, 64'(a_cnt_ill), 64'd0);
    chk({tag, "_cill32"}, 64'(b_cnt_ill), 64'd0);
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [21:0] s64;
    logic        i64;
    logic [21:0] s32;
    logic        i32;
  } vec_t;
  vec_t vecs[11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] snap, snap_ill;

    vecs[0]  = '{32'h00500093, 22'h2100C8, 1'b0, 22'h2100C8, 1'b0}; // addi
    vecs[1]  = '{32'h0040A103, 22'h2100D2, 1'b0, 22'h2100D2, 1'b0}; // lw
    vecs[2]  = '{32'h0010809B, 22'h21A0C8, 1'b0, 22'h000000, 1'b1}; // addiw
    vecs[3]  = '{32'h002081B3, 22'h2000A8, 1'b0, 22'h2000A8, 1'b0}; // add
    vecs[4]  = '{32'h402081B3, 22'h2010A8, 1'b0, 22'h2010A8, 1'b0}; // sub
    vecs[5]  = '{32'h00208463, 22'h030340, 1'b0, 22'h030340, 1'b0}; // beq
    vecs[6]  = '{32'h008000EF, 22'h2D0158, 1'b0, 22'h2D0158, 1'b0}; // jal
    vecs[7]  = '{32'h000010B7, 22'h240048, 1'b0, 22'h240048, 1'b0}; // lui
    vecs[8]  = '{32'h0020B023, 22'h1200C1, 1'b0, 22'h000000, 1'b1}; // sd
    vecs[9]  = '{32'h0000000F, 22'h000000, 1'b1, 22'h000000, 1'b1}; // fence: unsupported
    vecs[10] = '{32'h02009093, 22'h2170C8, 1'b0, 22'h000000, 1'b1}; // slli x1,x1,32

    build_table();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    check_all_zero("reset");

    // Directed decode vectors, one instruction at a time with EX always ready.
    foreach (vecs[i]) begin
      in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = {$urandom, $urandom}; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 64'(a_out_valid), 64'd1);
      chk($sformatf("vec%0d_sign64", i), 64'(a_out_sign), 64'(vecs[i].s64));
      chk($sformatf("vec%0d_ill64", i), 64'(a_out_illegal), 64'(vecs[i].i64));
      chk($sformatf("vec%0d_sign32", i), 64'(b_out_sign), 64'(vecs[i].s32));
      chk($sformatf("vec%0d_ill32", i), 64'(b_out_illegal), 64'(vecs[i].i32));
      snap_ill = b_cnt_ill;
      tick();
      chk($sformatf("vec%0d_cntill32", i), 64'(b_cnt_ill), 64'(snap_ill + CW'(vecs[i].i32)));
    end

    // Three-instruction stream against a stalled EX: fill the skid, then drain in order.
    snap = m_ret;
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 64'h100;
    tick();
    in_inst = 32'h00200113; in_pc = 64'h104;
    tick();
    chk("stream_in_ready", 64'(a_in_ready), 64'd0);
    chk("stream_head", 64'(a_out_inst), 64'h00100093);
    in_inst = 32'h00300193; in_pc = 64'h108;
    tick();
    chk("stream_hold_inst", 64'(a_out_inst), 64'h00100093);
    chk("stream_hold_ready", 64'(a_in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("stream_second", 64'(a_out_inst), 64'h00200113);
    tick();
    chk("stream_third", 64'(a_out_inst), 64'h00300193);
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 64'(a_out_valid), 64'd0);
    chk("stream_retired", 64'(a_cnt_ret), 64'(snap + CW'(3)));

    // Flush while the skid is occupied, with a new instruction on offer.
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00500093;
    tick();
    in_inst = 32'h0040A103;
    tick();
    snap = a_cnt_ret;
    flush = 1'b1; in_inst = 32'h002081B3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(a_out_valid), 64'd0);
    chk("flush_ready", 64'(a_in_ready), 64'd1);
    chk("flush_retired", 64'(a_cnt_ret), 64'(snap));
    tick();

    // Counter wrap: stream until the retire count reaches all-ones, then retire one more.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int n = 0; n < 600 && m_ret != {CW{1'b1}}; n++) begin
      in_inst = rand_inst(); in_pc = {$urandom, $urandom};
      tick();
    end
    chk("wrap_pre", 64'(a_cnt_ret), 64'({CW{1'b1}}));
    in_inst = rand_inst();
    tick();
    chk("wrap_post", 64'(a_cnt_ret), 64'd0);
    chk("wrap_post32", 64'(b_cnt_ret), 64'd0);

    // Reset mid-stream with both registers occupied.
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check_all_zero("midrst");

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      in_inst   = rand_inst();
      in_pc     = {$urandom, $urandom};
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
